ahb_sram_bridge: RTL and testbench
==================================

Name: ahb_sram_bridge

Overview:
- AHB-Lite slave that drives the 8 KB, 8-bit-wide synchronous SRAM model (cs_n/wen/oen, 13-bit address, 1-cycle registered read).
- Sits directly upstream of the SRAM.
- Breaks 32-bit AHB byte, halfword and word transfers into sequential byte accesses; inserts wait states through hready_out.
- Byte order is little-endian; byte lane = address[1:0].

Parameters:
ADDR_W, 13, SRAM byte-address width; haddr bits above ADDR_W-1 are ignored, so the SRAM aliases across the address space.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  asynchronous active-high reset.
hsel  in  1  slave select.
htrans  in  2  AHB transfer type; only NONSEQ and SEQ (htrans[1]=1) start a transfer.
hwrite  in  1  1 = write.
hsize  in  3  0 = byte, 1 = halfword, 2 = word.
haddr  in  32  byte address.
hwdata  in  32  write data, valid in the data phase.
hready  in  1  bus ready; address phase is accepted only when high.
hready_out  out  1  slave ready.
hresp  out  2  00 = OKAY, 01 = ERROR.
hrdata  out  32  read data.
sram_cs_n  out  1  SRAM chip select, active low.
sram_wen  out  1  SRAM write enable, active low.
sram_oen  out  1  SRAM output enable, active low.
sram_addr  out  ADDR_W  SRAM byte address.
sram_wdata  out  8  SRAM write byte.
sram_rdata  in  8  SRAM read byte; valid the cycle after a read is issued.

Behaviour:
- Reset (async, while rst=1):
  - FSM returns to IDLE; hready_out=1, hresp=00, hrdata=0.
  - sram_cs_n=1, sram_wen=1, sram_oen=1, sram_addr=0, sram_wdata=0.
  - A transfer in flight is abandoned; bytes already written stay written.
- Accept condition: hsel & hready & htrans[1] at a posedge.
  - Latch addr_q = haddr[ADDR_W-1:0] aligned down to the size.
  - Latch n = 1<<hsize (1, 2 or 4), hwrite, and cnt=0.
- IDLE or BUSY transfers, or hsel=0: zero-wait OKAY, no SRAM activity.
- FSM states: IDLE, WR, RD, RD_DONE (plus ERR1 and ERR2 with the optional feature).
- SRAM interface outputs are combinational from FSM state, cnt, addr_q, and write data:
  - sram_addr = addr_q + cnt.
  - Byte lane L = addr_q[1:0] + cnt.
- WR state, data-phase cycle k = 0..n-1:
  - sram_cs_n=0, sram_wen=0, sram_oen=1.
  - sram_wdata = lane L of the write data. Cycle 0 uses live hwdata; wdata_q latches hwdata in cycle 0 and supplies cycles 1..n-1.
  - hready_out=0 for k<n-1 and 1 at k=n-1.
  - Write latency = n cycles; a byte write has zero wait states.
- RD state, cycle k = 0..n-1:
  - sram_cs_n=0, sram_wen=1, sram_oen=0, issuing byte k.
  - At each posedge with k≥1, sram_rdata is captured into rd_buf lane L-1.
  - After issuing byte n-1, go to RD_DONE.
  - hready_out=0 throughout RD.
- RD_DONE (one cycle):
  - SRAM idle (cs_n=1).
  - hready_out=1, hrdata = rd_buf lanes, with the final lane taken directly from sram_rdata.
  - Unaccessed lanes read 0.
  - Read data phase = n+1 cycles.
- hrdata holds its last value outside RD_DONE.
- Pipelining: a new address phase can be accepted in the same cycle hready_out=1 completes a WR or RD_DONE. The next state is then WR or RD directly, with no IDLE bubble.
- Read-after-write to the same byte is coherent: the write lands at edge E and the read is issued after E.
- hresp=00 always unless the optional feature fires.

Optional Feature:
AHB_SRAM_ERR_EN
- Defined: an accepted transfer that is misaligned (hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]≠0), or that has hsize>2, performs no SRAM access.
  - ERR1: hready_out=0, hresp=01.
  - ERR2: hready_out=1, hresp=01; a new address phase may be accepted here.
- Undefined:
  - Misaligned addresses are silently aligned down.
  - hsize>2 is treated as a word transfer.
  - The ERR states do not exist.

Test Plan:
1. Word write haddr=0x4, hwdata=0xA1B2C3D4 -> SRAM writes 0xD4@4, 0xC3@5, 0xB2@6, 0xA1@7 on consecutive cycles; hready_out low for 3 cycles.
2. Word read haddr=0x4 after test 1 -> hrdata=0xA1B2C3D4 with hready_out high on the 5th data-phase cycle; hresp=00.
3. Byte write haddr=0x6, hwdata=0x00550000 (zero wait), then word read 0x4 -> 0xA155C3D4; halfword read 0x1FFE -> upper 16 bits = SRAM[0x1FFF:0x1FFE], lower 16 bits = 0.
4. Back-to-back write 0x10=0x12345678 followed immediately by a word read of 0x10 -> read address accepted on the write's final cycle; hrdata=0x12345678; no idle cycle between transfers.
5. Assert rst after 2 bytes of a word write to 0x20 (prior contents 0) -> sram_cs_n=1 and hready_out=1 immediately; a later read returns bytes 0 and 1 written, bytes 2 and 3 = 0.
6. With AHB_SRAM_ERR_EN: word read at 0x2 -> no sram_cs_n assertion; hresp=01 for 2 cycles, hready_out 0 then 1. Without the macro, the same transfer reads the word at 0x0.

Source files
------------

// File: rtl/ahb_sram_bridge.sv
// ahb_sram_bridge: AHB-Lite slave that serialises byte/halfword/word transfers onto an 8-bit synchronous SRAM.
// Optional feature macro AHB_SRAM_ERR_EN: misaligned or oversized transfers get a two-cycle ERROR response.
module ahb_sram_bridge #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       haddr,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [31:0]       hrdata,
  output logic              sram_cs_n,
  output logic              sram_wen,
  output logic              sram_oen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata
);

`ifdef AHB_SRAM_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RD_DONE, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_DONE} state_t;
`endif

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_n;
  logic [1:0]        r_cnt;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdbuf;
  logic [31:0]       r_hrdata;

  logic              w_accept;
  logic              w_last;
  logic [1:0]        w_lane;
  logic [1:0]        w_lanePrev;
  logic [1:0]        w_alignMask;
  logic [2:0]        w_n;
  logic [ADDR_W-1:0] w_alignAddr;
  logic [31:0]       w_wsrc;
  logic [31:0]       w_rdword;
  state_t            w_startState;
  logic              w_unused;

  // Upper address bits are ignored so the SRAM aliases across the whole bus space.
  assign w_unused = ^{htrans[0], haddr[31:ADDR_W]};

  assign w_last      = ({1'b0, r_cnt} == (r_n - 3'd1));
  assign w_lane      = r_addr[1:0] + r_cnt;
  assign w_lanePrev  = w_lane - 2'd1;
  assign w_wsrc      = (r_cnt == 2'd0) ? hwdata : r_wdata;
  assign w_accept    = hready_out & hsel & hready & htrans[1];
  assign w_alignAddr = haddr[ADDR_W-1:0] & {{(ADDR_W-2){1'b1}}, w_alignMask};
  assign sram_addr   = r_addr + ADDR_W'(r_cnt);

  always_comb begin
    w_n         = 3'd4;
    w_alignMask = 2'b00;
    case (hsize)
      3'd0: begin
        w_n         = 3'd1;
        w_alignMask = 2'b11;
      end
      3'd1: begin
        w_n         = 3'd2;
        w_alignMask = 2'b10;
      end
      default: ;
    endcase
  end

`ifdef AHB_SRAM_ERR_EN
  logic w_bad;
  assign w_bad = (hsize > 3'd2) ||
                 ((hsize == 3'd1) && haddr[0]) ||
                 ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_startState = w_bad ? S_ERR1 : (hwrite ? S_WR : S_RD);
`else
  assign w_startState = hwrite ? S_WR : S_RD;
`endif

  // The last byte of a read bypasses rd_buf so hrdata is valid in the completing cycle.
  always_comb begin
    w_rdword = r_rdbuf;
    w_rdword[{w_lane, 3'b000} +: 8] = sram_rdata;
  end

  assign hrdata = (r_state == S_RD_DONE) ? w_rdword : r_hrdata;

  always_comb begin
    hready_out = 1'b1;
    hresp      = 2'b00;
    case (r_state)
      S_WR:      hready_out = w_last;
      S_RD:      hready_out = 1'b0;
`ifdef AHB_SRAM_ERR_EN
      S_ERR1: begin
        hready_out = 1'b0;
        hresp      = 2'b01;
      end
      S_ERR2:    hresp = 2'b01;
`endif
      default: ;
    endcase
  end

  always_comb begin
    sram_cs_n  = 1'b1;
    sram_wen   = 1'b1;
    sram_oen   = 1'b1;
    sram_wdata = 8'h00;
    case (r_state)
      S_WR: begin
        sram_cs_n  = 1'b0;
        sram_wen   = 1'b0;
        sram_wdata = w_wsrc[{w_lane, 3'b000} +: 8];
      end
      S_RD: begin
        sram_cs_n = 1'b0;
        sram_oen  = 1'b0;
      end
      default: ;
    endcase
  end

  // An accept can only happen when hready_out is high, so it overrides the default completion path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_n      <= 3'd1;
      r_cnt    <= 2'd0;
      r_wdata  <= 32'h0;
      r_rdbuf  <= 32'h0;
      r_hrdata <= 32'h0;
    end else begin
      case (r_state)
        S_WR: begin
          if (r_cnt == 2'd0) r_wdata <= hwdata;
          if (w_last) r_state <= S_IDLE;
          else        r_cnt   <= r_cnt + 2'd1;
        end
        S_RD: begin
          if (r_cnt != 2'd0) r_rdbuf[{w_lanePrev, 3'b000} +: 8] <= sram_rdata;
          if (w_last) r_state <= S_RD_DONE;
          else        r_cnt   <= r_cnt + 2'd1;
        end
        S_RD_DONE: begin
          r_hrdata <= w_rdword;
          r_state  <= S_IDLE;
        end
`ifdef AHB_SRAM_ERR_EN
        S_ERR1: r_state <= S_ERR2;
        S_ERR2: r_state <= S_IDLE;
`endif
        default: r_state <= S_IDLE;
      endcase
      if (w_accept) begin
        r_state <= w_startState;
        r_addr  <= w_alignAddr;
        r_n     <= w_n;
        r_cnt   <= 2'd0;
        r_rdbuf <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb_ahb_sram_bridge: randomized AHB master plus 8 KB SRAM model, checked every cycle against a
// transaction-level model that expands each accepted transfer into its expected per-cycle outputs.
`timescale 1ns/1ps
module tb_ahb_sram_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hready;
   logic        hready_out;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic        sram_cs_n;
   logic        sram_wen;
   logic        sram_oen;
   logic [12:0] sram_addr;
   logic [7:0]  sram_wdata;
   logic [7:0]  sram_rdata = 8'h00;

   ahb_sram_bridge #(.ADDR_W(13)) dut (
      .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
      .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready(hready),
      .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata),
      .sram_cs_n(sram_cs_n), .sram_wen(sram_wen), .sram_oen(sram_oen),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // Expected outputs of one clock cycle, derived from the transfer that owns that cycle.
   typedef struct packed {
      logic        hrdy;
      logic [1:0]  resp;
      logic        csn;
      logic        wen;
      logic        oen;
      logic [12:0] addr;
      logic [7:0]  wdata;
      logic        isWr;
      logic        wrFirst;
      logic [31:0] wword;
      logic        rdDone;
      logic [31:0] hrdata;
   } rec_t;

   rec_t        pendQ[$];
   rec_t        chkQ[$];
   logic [7:0]  sramMem [0:8191];
   logic [7:0]  refMem  [0:8191];
   int          vectors = 0;
   int          miscompares = 0;
   int          cycleNo = 0;
   int          lastAccCycle = 0;
   bit          randHready = 0;
   logic [31:0] heldHrdata = 32'h0;
   logic [31:0] dutLastRead = 32'h0;
   logic [31:0] modelLastRead = 32'h0;

   // Behavioural SRAM: writes land at the edge, reads return one cycle after issue.
   always @(posedge clk) begin
      if (!sram_cs_n) begin
         if (!sram_wen) sramMem[sram_addr] <= sram_wdata;
         if (!sram_oen) sram_rdata <= sramMem[sram_addr];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rec_t idleRec();
      rec_t r;
      r = '0;
      r.hrdy = 1'b1;
      r.csn  = 1'b1;
      r.wen  = 1'b1;
      r.oen  = 1'b1;
      return r;
   endfunction

   // Expand an accepted transfer into the cycles of its data phase.
   task automatic buildTransfer(input bit wr, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
      int          n;
      int          lane;
      bit          err;
      logic [12:0] a;
      logic [31:0] word;
      rec_t        r;
      n = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
      a = ad[12:0] & ~13'(n - 1);
      err = 1'b0;
`ifdef AHB_SRAM_ERR_EN
      err = (sz > 3'd2) || ((int'(ad[1:0]) % n) != 0);
`endif
      if (err) begin
         r = idleRec();
         r.hrdy = 1'b0;
         r.resp = 2'b01;
         pendQ.push_back(r);
         r.hrdy = 1'b1;
         pendQ.push_back(r);
      end else if (wr) begin
         for (int k = 0; k < n; k++) begin
            r = idleRec();
            lane = int'(a[1:0]) + k;
            r.hrdy = (k == n - 1);
            r.csn = 1'b0;
            r.wen = 1'b0;
            r.addr = a + 13'(k);
            r.wdata = wd[lane*8 +: 8];
            r.isWr = 1'b1;
            r.wrFirst = (k == 0);
            r.wword = wd;
            pendQ.push_back(r);
         end
      end else begin
         word = 32'h0;
         for (int k = 0; k < n; k++) begin
            r = idleRec();
            lane = int'(a[1:0]) + k;
            r.hrdy = 1'b0;
            r.csn = 1'b0;
            r.oen = 1'b0;
            r.addr = a + 13'(k);
            pendQ.push_back(r);
            word[lane*8 +: 8] = refMem[a + 13'(k)];
         end
         r = idleRec();
         r.rdDone = 1'b1;
         r.hrdata = word;
         pendQ.push_back(r);
         modelLastRead = word;
      end
   endtask

   // One bus cycle: drive the address phase (transfer or not) and the data-phase write data.
   task automatic applyStimulus(input bit doXfer, input bit wr, input logic [2:0] sz,
                                input logic [31:0] ad, input logic [31:0] wd, output bit accepted);
      rec_t cur;
      if (pendQ.size() > 0) cur = pendQ.pop_front();
      else                  cur = idleRec();
      if (cur.rdDone) heldHrdata = cur.hrdata;
      cur.hrdata = heldHrdata;
      if (cur.isWr) refMem[cur.addr] = cur.wdata;
      hready = (randHready && ($urandom_range(0, 9) == 0)) ? 1'b0 : cur.hrdy;
      if (doXfer) begin
         hsel   = 1'b1;
         htrans = {1'b1, 1'($urandom_range(0, 1))};
         hwrite = wr;
         hsize  = sz;
         haddr  = ad;
      end else begin
         if ($urandom_range(0, 1) == 1) begin
            hsel   = 1'b0;
            htrans = 2'($urandom_range(0, 3));
         end else begin
            hsel   = 1'b1;
            htrans = {1'b0, 1'($urandom_range(0, 1))};
         end
         hwrite = 1'($urandom_range(0, 1));
         hsize  = 3'($urandom_range(0, 3));
         haddr  = $urandom;
      end
      hwdata = cur.wrFirst ? cur.wword : $urandom;
      chkQ.push_back(cur);
      accepted = doXfer && cur.hrdy && hready;
      if (accepted) begin
         lastAccCycle = cycleNo;
         buildTransfer(wr, sz, ad, wd);
      end
      cycleNo++;
      @(posedge clk);
      #1;
   endtask

   task automatic doTransfer(input bit wr, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
      bit acc;
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) applyStimulus(1'b1, wr, sz, ad, wd, acc);
      if (!acc) begin
         miscompares++;
         $display("[TB] FAIL accept_timeout: got no accept, expected accept of addr 0x%08h", ad);
      end
   endtask

   task automatic drain();
      bit acc;
      for (int t = 0; t < 40 && pendQ.size() > 0; t++) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, acc);
      if (pendQ.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL drain_timeout: got %0d pending cycles, expected 0", pendQ.size());
      end
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, acc);
   endtask

   // Single compare process: every cycle with an expectation is checked at the negedge.
   always @(negedge clk) begin : compare
      rec_t e;
      if (chkQ.size() > 0) begin
         e = chkQ.pop_front();
         checkOutput("hready_out", 32'(hready_out), 32'(e.hrdy));
         checkOutput("hresp", 32'(hresp), 32'(e.resp));
         checkOutput("sram_cs_n", 32'(sram_cs_n), 32'(e.csn));
         checkOutput("sram_wen", 32'(sram_wen), 32'(e.wen));
         checkOutput("sram_oen", 32'(sram_oen), 32'(e.oen));
         if (!e.csn) checkOutput("sram_addr", 32'(sram_addr), 32'(e.addr));
         if (e.isWr) checkOutput("sram_wdata", 32'(sram_wdata), 32'(e.wdata));
         checkOutput("hrdata", hrdata, e.hrdata);
         if (e.rdDone) dutLastRead = hrdata;
      end
   end

   initial begin : watchdog
      #5000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      logic [7:0]  initByte;
      logic [31:0] ad;
      int          wAcc;
      bit          acc;
      rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
      haddr = 32'h0; hwdata = 32'h0; hready = 1'b1;
      for (int i = 0; i < 8192; i++) begin
         initByte = 8'($urandom);
         sramMem[i] = initByte;
         refMem[i] = initByte;
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_hready_out", 32'(hready_out), 32'd1);
      checkOutput("rst_hresp", 32'(hresp), 32'd0);
      checkOutput("rst_hrdata", hrdata, 32'h0);
      checkOutput("rst_cs_n", 32'(sram_cs_n), 32'd1);
      checkOutput("rst_wen_oen", 32'({sram_wen, sram_oen}), 32'd3);
      checkOutput("rst_addr_wdata", 32'({sram_addr, sram_wdata}), 32'h0);
      rst = 1'b0;

      doTransfer(1'b1, 3'd2, 32'h4, 32'hA1B2C3D4);
      drain();
      checkOutput("t1_model_mem", {refMem[7], refMem[6], refMem[5], refMem[4]}, 32'hA1B2C3D4);
      doTransfer(1'b0, 3'd2, 32'h4, 32'h0);
      drain();
      checkOutput("t2_hrdata", dutLastRead, 32'hA1B2C3D4);
      checkOutput("t2_model", modelLastRead, 32'hA1B2C3D4);

      doTransfer(1'b1, 3'd0, 32'h6, 32'h00550000);
      doTransfer(1'b0, 3'd2, 32'h4, 32'h0);
      drain();
      checkOutput("t3_word_read", dutLastRead, 32'hA155C3D4);
      doTransfer(1'b1, 3'd1, 32'hFFFF_FFFE, 32'hBEEF0000);
      doTransfer(1'b0, 3'd1, 32'h1FFE, 32'h0);
      drain();
      checkOutput("t3_half_read_top", dutLastRead, 32'hBEEF0000);
      doTransfer(1'b0, 3'd0, 32'h5, 32'h0);
      drain();
      checkOutput("t3_byte_lane1", dutLastRead, 32'h0000C300);

      doTransfer(1'b1, 3'd2, 32'h10, 32'h12345678);
      wAcc = lastAccCycle;
      doTransfer(1'b0, 3'd2, 32'h10, 32'h0);
      checkOutput("t4_pipeline_gap", 32'(lastAccCycle - wAcc), 32'd4);
      drain();
      checkOutput("t4_hrdata", dutLastRead, 32'h12345678);

      doTransfer(1'b1, 3'd2, 32'h20, 32'h0);
      drain();
      doTransfer(1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, acc);
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, acc);
      rst = 1'b1;
      #1;
      checkOutput("t5_reset_cs_n", 32'(sram_cs_n), 32'd1);
      checkOutput("t5_reset_hready_out", 32'(hready_out), 32'd1);
      pendQ.delete();
      heldHrdata = 32'h0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      doTransfer(1'b0, 3'd2, 32'h20, 32'h0);
      drain();
      checkOutput("t5_partial_write", dutLastRead, 32'h0000BEEF);

      doTransfer(1'b1, 3'd2, 32'h0, 32'hCAFEF00D);
      drain();
      doTransfer(1'b0, 3'd2, 32'h2, 32'h0);
      drain();
`ifdef AHB_SRAM_ERR_EN
      checkOutput("t6_err_no_read", dutLastRead, 32'h0000BEEF);
`else
      checkOutput("t6_misaligned_word", dutLastRead, 32'hCAFEF00D);
`endif

      randHready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, acc);
         end else begin
            ad = $urandom;
            if ($urandom_range(0, 1) == 1) ad[12:6] = 7'h0;
            doTransfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), ad, $urandom);
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
